pixel_compositor: RTL and testbench

//  Per-pixel renderer directly downstream of the 640x480 VGA timing generator.
//  - Consumes col/row/valid/hsync/vsync and two fighter positions.
//  - Emits 6-bit RGB plus hsync/vsync delayed to match.
//  - Positions are double-buffered and committed only at the frame boundary, so a frame never tears.

---
 rtl/smoosh_pkg.sv | 22 ++
 rtl/pixel_compositor_box_hit.sv | 34 +++
 rtl/pixel_compositor.sv | 148 ++++++++++++++
 tb/tb_pixel_compositor.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/smoosh_pkg.sv
// Shared types and constants for the fighter-game pixel pipeline.
package smoosh_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned H_VAREA = 640;
    localparam int unsigned V_VAREA = 480;

    typedef logic [5:0] rgb_t;

    // {R[1:0],G[1:0],B[1:0]}
    localparam rgb_t C_BG    = 6'b000001;
    localparam rgb_t C_PLAT  = 6'b101010;
    localparam rgb_t C_P1    = 6'b110000;
    localparam rgb_t C_P2    = 6'b001100;
    localparam rgb_t C_WHITE = 6'b111111;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

endpackage

// File: rtl/pixel_compositor_box_hit.sv
// Combinational point-in-box test for one fighter; bounds use 11 bits so x+W never wraps.
module box_hit
    import smoosh_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned H = 48
) (
    input  logic [COORD_W-1:0] col,
    input  logic [COORD_W-1:0] row,
    input  pos_t               pos,
    output logic               hit
);

    logic [10:0] col_e;
    logic [10:0] row_e;
    logic [10:0] x_lo;
    logic [10:0] y_lo;
    logic [10:0] x_hi;
    logic [10:0] y_hi;
    logic        on_screen;

    always_comb begin
        col_e     = 11'(col);
        row_e     = 11'(row);
        x_lo      = 11'(pos.x);
        y_lo      = 11'(pos.y);
        x_hi      = x_lo + 11'(W);
        y_hi      = y_lo + 11'(H);
        on_screen = (x_lo < 11'(H_VAREA)) && (y_lo < 11'(V_VAREA));
        hit       = on_screen && (col_e >= x_lo) && (col_e < x_hi)
                              && (row_e >= y_lo) && (row_e < y_hi);
    end

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage per-pixel renderer: hit tests, priority colouring and frame-boundary position commit.
module pixel_compositor
    import smoosh_pkg::*;
#(
    parameter int unsigned SPR_W     = 32,
    parameter int unsigned SPR_H     = 48,
    parameter int unsigned PLAT_Y    = 400,
    parameter int unsigned PLAT_H    = 16,
    parameter int unsigned FLASH_DIV = 4,
    parameter int unsigned P1_X0     = 160,
    parameter int unsigned P1_Y0     = 352,
    parameter int unsigned P2_X0     = 448,
    parameter int unsigned P2_Y0     = 352
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] col,
    input  logic [COORD_W-1:0] row,
    input  logic               valid,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    input  logic               p1_flash,
    output rgb_t               rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam pos_t       P1_RST     = '{x: 10'(P1_X0), y: 10'(P1_Y0)};
    localparam pos_t       P2_RST     = '{x: 10'(P2_X0), y: 10'(P2_Y0)};
    // FLASH_DIV is a power of two, so it doubles as the mask for the phase bit.
    localparam logic [7:0] FLASH_MASK = 8'(FLASH_DIV);

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic               valid_q, valid_d;
    logic               hs1_q, hs1_d;
    logic               vs1_q, vs1_d;
    rgb_t               rgb_q, rgb_d;
    logic               hs2_q, hs2_d;
    logic               vs2_q, vs2_d;
    logic               fs_q, fs_d;
    pos_t               p1_pos_q, p1_pos_d;
    pos_t               p2_pos_q, p2_pos_d;
    logic               flash_q, flash_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    logic boundary;
    logic p1_hit;
    logic p2_hit;
    logic plat_hit;
    logic flash_phase;

    box_hit #(.W(SPR_W), .H(SPR_H)) u_p1_hit (
        .col (col_q),
        .row (row_q),
        .pos (p1_pos_q),
        .hit (p1_hit)
    );

    box_hit #(.W(SPR_W), .H(SPR_H)) u_p2_hit (
        .col (col_q),
        .row (row_q),
        .pos (p2_pos_q),
        .hit (p2_hit)
    );

    always_comb begin
        boundary    = (col == 10'd0) && (row == 10'(V_VAREA));
        plat_hit    = (11'(row_q) >= 11'(PLAT_Y)) && (11'(row_q) < 11'(PLAT_Y + PLAT_H));
        flash_phase = flash_q && ((frame_cnt_q & FLASH_MASK) != 8'd0);

        col_d       = col;
        row_d       = row;
        valid_d     = valid;
        hs1_d       = hsync_in;
        vs1_d       = vsync_in;
        hs2_d       = hs1_q;
        vs2_d       = vs1_q;
        fs_d        = boundary;
        p1_pos_d    = p1_pos_q;
        p2_pos_d    = p2_pos_q;
        flash_d     = flash_q;
        frame_cnt_d = frame_cnt_q;
        rgb_d       = '0;

        if (boundary) begin
            p1_pos_d    = '{x: p1_x, y: p1_y};
            p2_pos_d    = '{x: p2_x, y: p2_y};
            flash_d     = p1_flash;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        if (valid_q) begin
            if (p1_hit) begin
                rgb_d = flash_phase ? C_WHITE : C_P1;
            end else if (p2_hit) begin
                rgb_d = C_P2;
            end else if (plat_hit) begin
                rgb_d = C_PLAT;
            end else begin
                rgb_d = C_BG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            valid_q     <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            rgb_q       <= '0;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
            fs_q        <= 1'b0;
            p1_pos_q    <= P1_RST;
            p2_pos_q    <= P2_RST;
            flash_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            valid_q     <= valid_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            rgb_q       <= rgb_d;
            hs2_q       <= hs2_d;
            vs2_q       <= vs2_d;
            fs_q        <= fs_d;
            p1_pos_q    <= p1_pos_d;
            p2_pos_q    <= p2_pos_d;
            flash_q     <= flash_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rgb         = rgb_q;
    assign hsync       = hs2_q;
    assign vsync       = vs2_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: latency, box geometry, frame commit and flash cadence.
module tb_pixel_compositor;
    import smoosh_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] col, row;
    logic       valid, hsync_in, vsync_in;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_flash;
    rgb_t       rgb;
    logic       hsync, vsync, frame_start;

    int tests = 0;
    int fails = 0;
    int frames = 0;

    pixel_compositor dut (
        .clk (clk), .rst (rst), .col (col), .row (row), .valid (valid),
        .hsync_in (hsync_in), .vsync_in (vsync_in),
        .p1_x (p1_x), .p1_y (p1_y), .p2_x (p2_x), .p2_y (p2_y),
        .p1_flash (p1_flash), .rgb (rgb), .hsync (hsync), .vsync (vsync),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one visible pixel and return its colour two edges later.
    task automatic pix(input logic [9:0] c, input logic [9:0] r, input logic v, output rgb_t o);
        col = c; row = r; valid = v; hsync_in = 1'b1; vsync_in = 1'b1;
        tick();
        tick();
        o = rgb;
    endtask

    // Present the frame-boundary sample and check the commit pulse.
    task automatic boundary();
        col = 10'd0; row = 10'd480; valid = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        tick();
        frames++;
        chk("frame_start_pulse", 8'(frame_start), 8'd1);
        col = 10'd1;
        tick();
        chk("frame_start_drop", 8'(frame_start), 8'd0);
    endtask

    initial begin
        rgb_t o;
        rst = 1'b1; col = '0; row = '0; valid = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        p1_x = 10'd160; p1_y = 10'd352; p2_x = 10'd448; p2_y = 10'd352; p1_flash = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            col = 10'($urandom_range(799)); row = 10'($urandom_range(524));
            valid = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            tick();
            chk("rst_rgb", 8'(rgb), 8'd0);
            chk("rst_syncs", {6'd0, hsync, vsync}, 8'b11);
            chk("rst_fs", 8'(frame_start), 8'd0);
        end

        // 2: two-cycle latency for colour and sync
        rst = 1'b0; col = 10'd100; row = 10'd200; valid = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
        tick();
        chk("lat_n1_rgb", 8'(rgb), 8'd0);
        chk("lat_n1_hs", 8'(hsync), 8'd1);
        hsync_in = 1'b1;
        tick();
        chk("lat_n2_rgb", 8'(rgb), 8'(C_BG));
        chk("lat_n2_hs", 8'(hsync), 8'd0);

        // 3: default P1 edges on row 352
        pix(10'd159, 10'd352, 1'b1, o); chk("sweep_159", 8'(o), 8'(C_BG));
        pix(10'd160, 10'd352, 1'b1, o); chk("sweep_160", 8'(o), 8'(C_P1));
        pix(10'd191, 10'd352, 1'b1, o); chk("sweep_191", 8'(o), 8'(C_P1));
        pix(10'd192, 10'd352, 1'b1, o); chk("sweep_192", 8'(o), 8'(C_BG));
        pix(10'd191, 10'd399, 1'b1, o); chk("p1_bottom", 8'(o), 8'(C_P1));
        pix(10'd460, 10'd360, 1'b1, o); chk("p2_default", 8'(o), 8'(C_P2));
        pix(10'd10, 10'd399, 1'b1, o);  chk("plat_above", 8'(o), 8'(C_BG));
        pix(10'd10, 10'd400, 1'b1, o);  chk("plat_top", 8'(o), 8'(C_PLAT));
        pix(10'd10, 10'd415, 1'b1, o);  chk("plat_last", 8'(o), 8'(C_PLAT));
        pix(10'd10, 10'd416, 1'b1, o);  chk("plat_below", 8'(o), 8'(C_BG));
        pix(10'd170, 10'd360, 1'b0, o); chk("blank_in_box", 8'(o), 8'd0);

        // 4: pending position ignored until boundary
        p1_x = 10'd0;
        pix(10'd0, 10'd352, 1'b1, o);   chk("pend_hold_0", 8'(o), 8'(C_BG));
        pix(10'd170, 10'd352, 1'b1, o); chk("pend_hold_170", 8'(o), 8'(C_P1));
        boundary();
        pix(10'd0, 10'd352, 1'b1, o);   chk("commit_0", 8'(o), 8'(C_P1));
        pix(10'd31, 10'd352, 1'b1, o);  chk("commit_31", 8'(o), 8'(C_P1));
        pix(10'd32, 10'd352, 1'b1, o);  chk("commit_32", 8'(o), 8'(C_BG));

        // 5: overlap, then right-edge clipping
        p1_x = 10'd300; p1_y = 10'd100; p2_x = 10'd300; p2_y = 10'd100;
        boundary();
        pix(10'd300, 10'd100, 1'b1, o); chk("ovl_tl", 8'(o), 8'(C_P1));
        pix(10'd331, 10'd147, 1'b1, o); chk("ovl_br", 8'(o), 8'(C_P1));
        pix(10'd332, 10'd100, 1'b1, o); chk("ovl_out", 8'(o), 8'(C_BG));
        p1_x = 10'd620;
        boundary();
        pix(10'd300, 10'd100, 1'b1, o); chk("p2_revealed", 8'(o), 8'(C_P2));
        pix(10'd619, 10'd110, 1'b1, o); chk("clip_619", 8'(o), 8'(C_BG));
        pix(10'd620, 10'd110, 1'b1, o); chk("clip_620", 8'(o), 8'(C_P1));
        pix(10'd639, 10'd110, 1'b1, o); chk("clip_639", 8'(o), 8'(C_P1));
        p1_x = 10'd700; p2_x = 10'd300; p2_y = 10'd384;
        boundary();
        pix(10'd639, 10'd110, 1'b1, o); chk("p1_invisible", 8'(o), 8'(C_BG));
        pix(10'd310, 10'd410, 1'b1, o); chk("p2_on_plat", 8'(o), 8'(C_P2));

        // Mid-frame reset drops in-flight data and restores defaults
        col = 10'd310; row = 10'd410; valid = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_rgb", 8'(rgb), 8'd0);
        chk("midrst_syncs", {6'd0, hsync, vsync}, 8'b11);
        rst = 1'b0; frames = 0;
        pix(10'd170, 10'd352, 1'b1, o); chk("midrst_p1_default", 8'(o), 8'(C_P1));
        pix(10'd310, 10'd410, 1'b1, o); chk("midrst_p2_default", 8'(o), 8'(C_PLAT));

        // 6: flash cadence over 16 frames
        p1_x = 10'd160; p1_y = 10'd352; p2_x = 10'd448; p2_y = 10'd352; p1_flash = 1'b1;
        for (int f = 0; f < 16; f++) begin
            boundary();
            pix(10'd170, 10'd360, 1'b1, o);
            chk($sformatf("flash_f%0d", frames), 8'(o), ((frames & 4) != 0) ? 8'(C_WHITE) : 8'(C_P1));
            pix(10'd170, 10'd360, 1'b0, o);
            chk($sformatf("flash_blank_f%0d", frames), 8'(o), 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
